// File: rtl/cmd_mem_pkg.sv
// Shared defaults, types and helpers for the banked command memory.
package cmd_mem_pkg;

  localparam int CMD_ADDR_WIDTH_DEF = 8;
  localparam int MEM_WIDTH_DEF      = 32;
  localparam int MEM_TO_CMD_DEF     = 4;

  typedef logic [MEM_WIDTH_DEF-1:0] cmd_word_t;

  // Bank idx occupies cmd_out[bank_lsb(idx, width) +: width].
  function automatic int bank_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cmd_mem_bank.sv
// One simple dual-port RAM bank: single write port, registered read-first read port.
module cmd_mem_bank #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Array is sampled before this edge's write lands, giving read-first on collision.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cmd_mem_array.sv
// Banked command memory: MEM_TO_CMD banks fetched side by side into one command word.
// Define CMD_MEM_OUTREG_EN to add an output pipeline register (fetch latency 2 instead of 1).
module cmd_mem_array
  import cmd_mem_pkg::*;
#(
  parameter int CMD_ADDR_WIDTH = CMD_ADDR_WIDTH_DEF,
  parameter int MEM_WIDTH      = MEM_WIDTH_DEF,
  parameter int MEM_TO_CMD     = MEM_TO_CMD_DEF
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              write_enable,
  input  logic [$clog2(MEM_TO_CMD)-1:0]     write_mem_sel,
  input  logic [CMD_ADDR_WIDTH-1:0]         write_address,
  input  logic [MEM_WIDTH-1:0]              cmd_in,
  input  logic                              read_enable,
  input  logic [CMD_ADDR_WIDTH-1:0]         read_address,
  output logic [MEM_WIDTH*MEM_TO_CMD-1:0]   cmd_out,
  output logic                              cmd_valid
);

  localparam int SEL_W = $clog2(MEM_TO_CMD);
  localparam int CMD_W = MEM_WIDTH * MEM_TO_CMD;

  logic             sel_ok;
  logic [CMD_W-1:0] cmd_p0;
  logic             vld_p0_d;
  logic             vld_p0_q;

  // Non-power-of-two bank counts leave select codes that must not write anywhere.
  assign sel_ok = int'(write_mem_sel) < MEM_TO_CMD;

  for (genvar i = 0; i < MEM_TO_CMD; i++) begin : g_bank
    cmd_mem_bank #(
      .ADDR_W (CMD_ADDR_WIDTH),
      .DATA_W (MEM_WIDTH)
    ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (write_enable && sel_ok && (write_mem_sel == SEL_W'(i))),
      .wr_addr (write_address),
      .wr_data (cmd_in),
      .rd_en   (read_enable),
      .rd_addr (read_address),
      .rd_data (cmd_p0[bank_lsb(i, MEM_WIDTH) +: MEM_WIDTH])
    );
  end

  // Stage p0: bank read registers plus their valid flag.
  always_comb begin
    vld_p0_d = read_enable;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
    end
  end

`ifdef CMD_MEM_OUTREG_EN
  logic [CMD_W-1:0] cmd_p1_d;
  logic [CMD_W-1:0] cmd_p1_q;
  logic             vld_p1_d;
  logic             vld_p1_q;

  // Stage p1: retiming register behind the RAM outputs; holds between fetches.
  always_comb begin
    cmd_p1_d = cmd_p1_q;
    vld_p1_d = vld_p0_q;
    if (vld_p0_q) begin
      cmd_p1_d = cmd_p0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_p1_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      cmd_p1_q <= cmd_p1_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  assign cmd_out   = cmd_p1_q;
  assign cmd_valid = vld_p1_q;
`else
  assign cmd_out   = cmd_p0;
  assign cmd_valid = vld_p0_q;
`endif

endmodule

// File: tb/tb_cmd_mem_array.sv
// Directed self-checking bench for cmd_mem_array (either fetch-latency build).
module tb_cmd_mem_array;

`ifdef CMD_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         reset_n;
  logic         write_enable;
  logic [1:0]   write_mem_sel;
  logic [7:0]   write_address;
  logic [31:0]  cmd_in;
  logic         read_enable;
  logic [7:0]   read_address;
  logic [127:0] cmd_out;
  logic         cmd_valid;

  int total;
  int bad;

  cmd_mem_array dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_enable  (write_enable),
    .write_mem_sel (write_mem_sel),
    .write_address (write_address),
    .cmd_in        (cmd_in),
    .read_enable   (read_enable),
    .read_address  (read_address),
    .cmd_out       (cmd_out),
    .cmd_valid     (cmd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int bank, input int addr, input logic [31:0] data);
    write_enable  = 1'b1;
    write_mem_sel = 2'(bank);
    write_address = 8'(addr);
    cmd_in        = data;
    step();
    write_enable  = 1'b0;
  endtask

  task automatic fetch(input int addr);
    read_enable  = 1'b1;
    read_address = 8'(addr);
    step();
    read_enable  = 1'b0;
    repeat (LAT - 1) step();
  endtask

  task automatic test_reset();
    logic [127:0] held;
    reset_n     = 1'b0;
    read_enable = 1'b1;
    read_address = 8'd0;
    repeat (3) step();
    total++;
    if (cmd_out !== 128'h0) begin
      bad++;
      $display("FAIL reset_cmd_out got=%h exp=%h", cmd_out, 128'h0);
    end
    total++;
    if (cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid);
    end
    read_enable = 1'b0;
    reset_n     = 1'b1;
    step();
    fetch(0);
    total++;
    if (cmd_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_fetch_valid got=%b exp=1", cmd_valid);
    end
    total++;
    if (cmd_out !== 128'h0) begin
      bad++;
      $display("FAIL first_fetch_data got=%h exp=%h", cmd_out, 128'h0);
    end
    held = cmd_out;
    step();
    total++;
    if (cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_pulse got=%b exp=0", cmd_valid);
    end
    total++;
    if (cmd_out !== held) begin
      bad++;
      $display("FAIL hold_cmd_out got=%h exp=%h", cmd_out, held);
    end
  endtask

  task automatic test_bank_placement();
    wr(0, 5, 32'h11111111);
    wr(1, 5, 32'h22222222);
    wr(2, 5, 32'h33333333);
    wr(3, 5, 32'h44444444);
    fetch(5);
    total++;
    if (cmd_out !== 128'h44444444_33333333_22222222_11111111) begin
      bad++;
      $display("FAIL placement got=%h exp=%h", cmd_out,
               128'h44444444_33333333_22222222_11111111);
    end
    total++;
    if (cmd_valid !== 1'b1) begin
      bad++;
      $display("FAIL placement_valid got=%b exp=1", cmd_valid);
    end
  endtask

  task automatic test_bank_isolation();
    wr(2, 7, 32'hDEADBEEF);
    fetch(7);
    total++;
    if (cmd_out !== 128'h00000000_DEADBEEF_00000000_00000000) begin
      bad++;
      $display("FAIL isolation got=%h exp=%h", cmd_out,
               128'h00000000_DEADBEEF_00000000_00000000);
    end
    fetch(6);
    total++;
    if (cmd_out !== 128'h0) begin
      bad++;
      $display("FAIL isolation_neighbour got=%h exp=%h", cmd_out, 128'h0);
    end
  endtask

  task automatic test_collision();
    wr(0, 3, 32'h0000000A);
    write_enable  = 1'b1;
    write_mem_sel = 2'd0;
    write_address = 8'd3;
    cmd_in        = 32'h0000000B;
    read_enable   = 1'b1;
    read_address  = 8'd3;
    step();
    write_enable  = 1'b0;
    read_enable   = 1'b0;
    repeat (LAT - 1) step();
    total++;
    if (cmd_out !== 128'hA) begin
      bad++;
      $display("FAIL collision_old got=%h exp=%h", cmd_out, 128'hA);
    end
    fetch(3);
    total++;
    if (cmd_out !== 128'hB) begin
      bad++;
      $display("FAIL collision_new got=%h exp=%h", cmd_out, 128'hB);
    end
  endtask

  task automatic test_streaming();
    logic [127:0] exp;
    int idx;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 4; b++) begin
        wr(b, a, 32'(a));
      end
    end
    for (int cyc = 0; cyc < 256 + LAT - 1; cyc++) begin
      read_enable  = (cyc < 256);
      read_address = 8'(cyc);
      step();
      idx = cyc - (LAT - 1);
      if (idx >= 0) begin
        exp = {4{32'(idx)}};
        total++;
        if (cmd_valid !== 1'b1 || cmd_out !== exp) begin
          bad++;
          $display("FAIL stream_%0d got=%b/%h exp=1/%h", idx, cmd_valid, cmd_out, exp);
        end
      end
    end
    read_enable = 1'b0;
    step();
    total++;
    if (cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_end_valid got=%b exp=0", cmd_valid);
    end
  endtask

  task automatic test_mid_fetch_reset();
    read_enable  = 1'b1;
    read_address = 8'd9;
    step();
    read_enable  = 1'b0;
    reset_n      = 1'b0;
    #2;
    total++;
    if (cmd_valid !== 1'b0 || cmd_out !== 128'h0) begin
      bad++;
      $display("FAIL midreset_async got=%b/%h exp=0/0", cmd_valid, cmd_out);
    end
    #2;
    reset_n = 1'b1;
    repeat (LAT) step();
    total++;
    if (cmd_valid !== 1'b0 || cmd_out !== 128'h0) begin
      bad++;
      $display("FAIL midreset_discard got=%b/%h exp=0/0", cmd_valid, cmd_out);
    end
    fetch(9);
    total++;
    if (cmd_valid !== 1'b1 || cmd_out !== {4{32'd9}}) begin
      bad++;
      $display("FAIL midreset_refetch got=%b/%h exp=1/%h", cmd_valid, cmd_out, {4{32'd9}});
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset_n       = 1'b0;
    write_enable  = 1'b0;
    write_mem_sel = 2'd0;
    write_address = 8'd0;
    cmd_in        = 32'd0;
    read_enable   = 1'b0;
    read_address  = 8'd0;
    test_reset();
    test_bank_placement();
    test_bank_isolation();
    test_collision();
    test_streaming();
    test_mid_fetch_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
